frame_sync: RTL and testbench
=============================

Name: frame_sync

Overview:
- Bit-serial frame synchroniser that sits directly upstream of the additive scrambler/descrambler.
- Hunts for a fixed sync word in the incoming serial stream, confirms frame alignment over several periods, then flywheels on it.
- Strips sync bits and forwards only payload bits, with a valid strobe.
- Emits a one-cycle `set` pulse one cycle before payload bit 0 of every frame, so the downstream scrambler reloads its key register exactly at frame start.

Parameters:
- SYNC_LEN, 16, sync word length in bits (2..32).
- SYNC_WORD, 32'h0000_F628, sync pattern in bits [SYNC_LEN-1:0], MSB received first; must be non-zero.
- FRAME_LEN, 256, payload bits per frame (>=1).
- CONFIRM, 2, consecutive sync hits needed to declare lock (>=1).
- MISS_MAX, 3, consecutive sync misses in LOCK that drop to HUNT (>=1).

Ports:
- clk  in  1  clock.
- rst_  in  1  reset, asynchronous, active-high.
- in  in  1  serial input bit.
- in_valid  in  1  `in` is consumed on this edge only when high.
- out  out  1  registered payload bit.
- out_valid  out  1  `out` holds a payload bit this cycle.
- set  out  1  one-cycle frame-start pulse to the scrambler.
- locked  out  1  high while state == LOCK.

Behaviour:
- Reset, asynchronous, active-high: state=HUNT; shreg=0; fill=0; cnt=0; hits=0; misses=0; out, out_valid, set, locked all 0.
- Frame period P = SYNC_LEN + FRAME_LEN. cnt ranges 0..P-1. Payload bits occupy cnt 0..FRAME_LEN-1; sync bits occupy FRAME_LEN..P-1.
- All state advances only on edges with in_valid=1. With in_valid=0, every register holds except out_valid and set, which are forced to 0 (both are single-cycle strobes).
- match is combinational: `{shreg[SYNC_LEN-2:0], in} == SYNC_WORD[SYNC_LEN-1:0]`, qualified by fill >= SYNC_LEN-1.
  - fill saturates at SYNC_LEN-1.
  - fill is not cleared on re-entry to HUNT.
- shreg shifts `in` in at the LSB on every accepted bit.
- HUNT:
  - Check match on every accepted bit.
  - On match: cnt<=0 and hits<=1.
  - If CONFIRM==1: go to LOCK, set<=1, misses<=0. Otherwise go to VERIFY.
- VERIFY:
  - cnt increments, wrapping P-1 -> 0.
  - At cnt==P-1 with match: hits++. If hits+1==CONFIRM, go to LOCK, set<=1, misses<=0.
  - At cnt==P-1 without match: go to HUNT, hits<=0.
  - No payload is output in VERIFY.
- LOCK:
  - cnt increments, wrapping as in VERIFY.
  - At cnt==P-1 with match: misses<=0, set<=1.
  - At cnt==P-1 without match: misses++.
    - If misses+1==MISS_MAX: go to HUNT, no set pulse, locked<=0.
    - Otherwise set<=1 (flywheel pulse keeps the scrambler aligned).
- Payload path: on an accepted bit in LOCK with cnt<FRAME_LEN, out<=in and out_valid<=1. Otherwise out_valid<=0 and out holds its value.
- Latency: 1 cycle from `in` to `out`. set is high in the cycle after the last sync bit is accepted; payload bit 0 appears on `out` on the next accepted edge.
- locked is registered and mirrors the state: rises with the same edge that raises set on entry to LOCK, and falls on the edge that enters HUNT.
- Loss of lock mid-frame is impossible; exit from LOCK happens only at cnt==P-1.
- Reset mid-frame returns to HUNT immediately, with all outputs low in the same cycle (asynchronous).

Decomposition:
- frame_sync_pkg holds:
  - typedef enum logic [1:0] {HUNT, VERIFY, LOCK} fs_state_t;
  - constant DEFAULT_SYNC_WORD = 32'h0000_F628.
- One sub-module, frame_sync_match: shift register, fill counter and comparator, producing match. It is instantiated once.
- FSM, counters and output registers stay in frame_sync.

Test Plan (SYNC_LEN=8, SYNC_WORD=8'hB8, FRAME_LEN=16, CONFIRM=2, MISS_MAX=2, P=24; in_valid=1 unless stated):
- Clean frames: 4 frames of {B8, 16 payload bits} -> locked rises after the 2nd sync. set pulses once per frame from the 2nd sync on. Exactly 16 out_valid cycles per locked frame. out equals the payload bits delayed 1 cycle.
- False sync: a single B8 inside payload, followed by non-sync at the P boundary -> HUNT -> VERIFY -> HUNT. locked, set and out_valid never assert.
- Flywheel: after lock, corrupt one sync (8'hB9) -> locked stays 1, set still pulses, payload still forwarded. Corrupt 2 consecutive syncs -> locked falls at the 2nd boundary, no set pulse at that boundary.
- Stall: drive in_valid low for 3 cycles at random points in a locked frame -> out_valid and set are low during the stalls. Payload order and count are unchanged; alignment is kept.
- Reset mid-frame: assert rst_ at cnt=5 while locked -> out, out_valid, set and locked are 0 asynchronously. After release, re-lock takes 2 sync periods.
- Downstream alignment: connect scrambler set/in to set/out -> the scrambler key loads exactly once per frame, in the cycle before payload bit 0.

Source files
------------

// File: rtl/frame_sync_pkg.sv
// frame_sync_pkg: shared state type and default sync pattern for the frame synchroniser
package frame_sync_pkg;

    typedef enum logic [1:0] {HUNT, VERIFY, LOCK} fs_state_t;

    localparam logic [31:0] DEFAULT_SYNC_WORD = 32'h0000_F628;

endpackage

// File: rtl/frame_sync_match.sv
// frame_sync_match: serial shift register, fill counter and sync-word comparator
module frame_sync_match
    import frame_sync_pkg::*;
#(
    parameter int unsigned SYNC_LEN  = 16,
    parameter logic [31:0] SYNC_WORD = DEFAULT_SYNC_WORD
) (
    input  logic clk,
    input  logic rst_,
    input  logic in,
    input  logic in_valid,
    output logic match
);
    localparam int unsigned FW = $clog2(SYNC_LEN);
    localparam logic [FW-1:0] FULL = FW'(SYNC_LEN - 1);

    logic [SYNC_LEN-2:0] shreg_q, shreg_d;
    logic [FW-1:0]       fill_q, fill_d;
    logic [SYNC_LEN-1:0] window;

    // the window includes the bit being offered now, so a hit is seen on the edge that accepts the last sync bit
    assign window  = {shreg_q, in};
    assign shreg_d = in_valid ? window[SYNC_LEN-2:0] : shreg_q;
    assign fill_d  = (in_valid && fill_q != FULL) ? fill_q + 1'b1 : fill_q;
    assign match   = (fill_q == FULL) && (window == SYNC_WORD[SYNC_LEN-1:0]);

    // history and fill count; fill saturates and survives returns to HUNT
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            shreg_q <= '0;
            fill_q  <= '0;
        end else begin
            shreg_q <= shreg_d;
            fill_q  <= fill_d;
        end
    end

endmodule

// File: rtl/frame_sync.sv
// frame_sync: hunts for the sync word, confirms and flywheels on it, forwards payload and pulses set at frame start
module frame_sync
    import frame_sync_pkg::*;
#(
    parameter int unsigned SYNC_LEN  = 16,
    parameter logic [31:0] SYNC_WORD = DEFAULT_SYNC_WORD,
    parameter int unsigned FRAME_LEN = 256,
    parameter int unsigned CONFIRM   = 2,
    parameter int unsigned MISS_MAX  = 3
) (
    input  logic clk,
    input  logic rst_,
    input  logic in,
    input  logic in_valid,
    output logic out,
    output logic out_valid,
    output logic set,
    output logic locked
);
    localparam int unsigned P  = SYNC_LEN + FRAME_LEN;
    localparam int unsigned CW = $clog2(P);
    localparam int unsigned HW = $clog2(CONFIRM + 1);
    localparam int unsigned MW = $clog2(MISS_MAX + 1);
    localparam logic [CW-1:0] LAST     = CW'(P - 1);
    localparam logic [CW-1:0] SYNC_BEG = CW'(FRAME_LEN);

    fs_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [HW-1:0] hits_q, hits_d;
    logic [MW-1:0] misses_q, misses_d;
    logic          out_q, out_d;
    logic          out_valid_q, out_valid_d;
    logic          set_q, set_d;
    logic          locked_q, locked_d;
    logic          match;
    logic          at_end;

    frame_sync_match #(
        .SYNC_LEN  (SYNC_LEN),
        .SYNC_WORD (SYNC_WORD)
    ) u_match (
        .clk      (clk),
        .rst_     (rst_),
        .in       (in),
        .in_valid (in_valid),
        .match    (match)
    );

    assign cnt_inc = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    assign at_end  = (cnt_q == LAST);

    // next state: sync is only judged at the period boundary once a candidate alignment exists
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hits_d      = hits_q;
        misses_d    = misses_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        set_d       = 1'b0;
        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    if (match) begin
                        cnt_d  = '0;
                        hits_d = HW'(1);
                        if (CONFIRM == 1) begin
                            state_d  = LOCK;
                            set_d    = 1'b1;
                            misses_d = '0;
                        end else begin
                            state_d = VERIFY;
                        end
                    end
                end
                VERIFY: begin
                    cnt_d = cnt_inc;
                    if (at_end) begin
                        if (match) begin
                            hits_d = hits_q + HW'(1);
                            if (hits_d == HW'(CONFIRM)) begin
                                state_d  = LOCK;
                                set_d    = 1'b1;
                                misses_d = '0;
                            end
                        end else begin
                            state_d = HUNT;
                            hits_d  = '0;
                        end
                    end
                end
                LOCK: begin
                    cnt_d = cnt_inc;
                    if (cnt_q < SYNC_BEG) begin
                        out_d       = in;
                        out_valid_d = 1'b1;
                    end
                    if (at_end) begin
                        if (match) begin
                            misses_d = '0;
                            set_d    = 1'b1;
                        end else begin
                            misses_d = misses_q + MW'(1);
                            state_d  = (misses_d == MW'(MISS_MAX)) ? HUNT : LOCK;
                            set_d    = (misses_d != MW'(MISS_MAX));
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        locked_d = (state_d == LOCK);
    end

    // state, counters and registered outputs
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            state_q     <= HUNT;
            cnt_q       <= '0;
            hits_q      <= '0;
            misses_q    <= '0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            set_q       <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hits_q      <= hits_d;
            misses_q    <= misses_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            set_q       <= set_d;
            locked_q    <= locked_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign set       = set_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_frame_sync.sv
// tb_frame_sync: scoreboard bench for frame_sync with directed frames, flywheel, stall and reset cases
module tb_frame_sync;

    logic clk = 1'b0;
    logic rst_ = 1'b0;
    logic din = 1'b0;
    logic din_v = 1'b0;
    logic dout, dout_v, dset, dlock;

    int n_cmp = 0;
    int n_fail = 0;
    int set_cnt = 0;
    int ov_cnt = 0;
    int set_snap, ov_snap;

    typedef struct packed {
        logic b;
        logic first;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    frame_sync #(
        .SYNC_LEN  (8),
        .SYNC_WORD (32'h0000_00B8),
        .FRAME_LEN (16),
        .CONFIRM   (2),
        .MISS_MAX  (2)
    ) dut (
        .clk       (clk),
        .rst_      (rst_),
        .in        (din),
        .in_valid  (din_v),
        .out       (dout),
        .out_valid (dout_v),
        .set       (dset),
        .locked    (dlock)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic b, input logic v);
        din   = b;
        din_v = v;
        @(posedge clk);
        #1;
    endtask

    task automatic stall();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0);
            chk("stall_out_valid", dout_v, 0);
            chk("stall_set", dset, 0);
        end
    endtask

    // one period: sync byte then payload, MSB first; nb bits sent, optional 3-cycle stall before bit stall_at
    task automatic frame(input logic [7:0] s, input logic [15:0] p, input bit fwd,
                         input bit exp_lk, input int stall_at, input int nb);
        logic [23:0] bits;
        bits = {s, p};
        for (int i = 0; i < nb; i++) begin
            if (i == stall_at) stall();
            if (fwd && i >= 8) exp_q.push_back('{b: bits[23-i], first: (i == 8)});
            drive(bits[23-i], 1'b1);
            if (i == 7) begin
                chk("locked_after_sync", dlock, exp_lk);
                chk("set_after_sync", dset, exp_lk);
            end
        end
    endtask

    task automatic monitor();
        bit   armed;
        exp_t e;
        armed = 1'b0;
        forever begin
            @(negedge clk);
            if (dset) begin
                set_cnt++;
                armed = 1'b1;
            end
            if (dout_v) begin
                ov_cnt++;
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", dout_v, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("payload_bit", dout, e.b);
                    chk("set_before_bit0", armed, e.first);
                end
                armed = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            monitor();
        join_none
        #1 rst_ = 1'b1;
        #2;
        chk("reset_out", dout, 0);
        chk("reset_out_valid", dout_v, 0);
        chk("reset_set", dset, 0);
        chk("reset_locked", dlock, 0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_ = 1'b0;
        @(posedge clk);
        #1;
        // clean frames: lock on the second sync
        frame(8'hB8, 16'hA5C3, 0, 0, -1, 24);
        frame(8'hB8, 16'h1234, 1, 1, -1, 24);
        frame(8'hB8, 16'hFFFF, 1, 1, -1, 24);
        frame(8'hB8, 16'h0001, 1, 1, -1, 24);
        // flywheel over one bad sync, drop after two in a row
        frame(8'hB9, 16'h8421, 1, 1, -1, 24);
        frame(8'hB8, 16'h7E81, 1, 1, -1, 24);
        frame(8'hB9, 16'hC0DE, 1, 1, -1, 24);
        frame(8'hB9, 16'h0000, 0, 0, -1, 24);
        // false sync: VERIFY then back to HUNT
        set_snap = set_cnt;
        ov_snap  = ov_cnt;
        frame(8'hB8, 16'h5A5A, 0, 0, -1, 24);
        frame(8'h3C, 16'h0000, 0, 0, -1, 24);
        chk("false_sync_set_pulses", set_cnt - set_snap, 0);
        chk("false_sync_out_valids", ov_cnt - ov_snap, 0);
        // relock, then stalls inside payload and inside sync
        frame(8'hB8, 16'h1111, 0, 0, -1, 24);
        frame(8'hB8, 16'h2222, 1, 1, -1, 24);
        frame(8'hB8, 16'hABCD, 1, 1, 14, 24);
        frame(8'hB8, 16'h3C3C, 1, 1, 3, 24);
        // reset at cnt=5 while locked
        frame(8'hB8, 16'hF800, 1, 1, -1, 13);
        #5;
        chk("pre_reset_locked", dlock, 1);
        chk("pre_reset_out", dout, 1);
        din_v = 1'b0;
        rst_  = 1'b1;
        #1;
        chk("async_reset_out", dout, 0);
        chk("async_reset_out_valid", dout_v, 0);
        chk("async_reset_set", dset, 0);
        chk("async_reset_locked", dlock, 0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_ = 1'b0;
        @(posedge clk);
        #1;
        frame(8'hB8, 16'h4321, 0, 0, -1, 24);
        frame(8'hB8, 16'h9999, 1, 1, -1, 24);
        repeat (3) drive(1'b0, 1'b0);
        chk("total_set_pulses", set_cnt, 11);
        chk("total_out_valid", ov_cnt, 165);
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
